dvi_frame_sample_ctrl: RTL
==========================

Name: dvi_frame_sample_ctrl

Overview:
- Controller between DVI_RX and the LED-matrix SPI path. Runs in the recovered pixel-clock domain.
- Tracks DVI timing (vs/de) and decimates each active frame onto a GRID_W x GRID_H sample grid. It writes one RGB sample per grid cell into a double-banked frame buffer.
- At each frame boundary it hands the completed bank to the SPI transmitter with a start/busy handshake, dropping frames when the transmitter is still busy.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 720, active lines per frame
- GRID_W, 64, sample columns (4 panels x 16)
- GRID_H, 32, sample rows (4 panels x 8)
- VS_POL, 1, vs active level (1 = active-high)

Derived constants:
- STEP_X = H_ACTIVE/GRID_W; STEP_Y = V_ACTIVE/GRID_H (integer floor).
- AW = $clog2(GRID_W*GRID_H) + 1.

Ports:
- clk  in  1  pixel clock (DVI_RX O_rgb_clk)
- rst  in  1  synchronous reset, active-high
- enable  in  1  capture enable
- pll_lock  in  1  DVI_RX O_pll_phase_lock
- vs  in  1  vertical sync
- de  in  1  data enable
- rgb  in  24  {r,g,b}, 8 bits each
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  AW  {bank, gy, gx}
- wr_data  out  24  sampled pixel
- tx_start  out  1  one-cycle pulse: bank tx_bank is ready
- tx_bank  out  1  bank handed to transmitter
- tx_busy  in  1  transmitter busy
- frame_err  out  1  one-cycle pulse: incomplete frame discarded
- drop_cnt  out  8  saturating count of dropped frames

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; capture bank 0; all counters 0.
- Edge detection:
  - vs_edge = vs transitions to VS_POL (registered previous value).
  - de_rise and de_fall come from a registered de.
- Counters:
  - x_cnt resets to 0 on de_rise and increments while de is high.
  - line_cnt increments on de_fall.
  - Both reset on vs_edge.
  - Cell sub-counters (x_sub, gx) and (y_sub, gy) are derived incrementally; no dividers.
- Sample condition:
  - de && x_sub==STEP_X/2 && y_sub==STEP_Y/2 && gx<GRID_W && gy<GRID_H.
  - On a sample, the next cycle has wr_en=1, wr_addr={cap_bank,gy,gx} and wr_data=rgb. Latency is 1 cycle.
  - Pixels beyond GRID_W*STEP_X or GRID_H*STEP_Y are ignored.
- FSM states: IDLE, SYNC, CAPTURE, HANDOFF.
  - IDLE: entered when !enable || !pll_lock. Go to SYNC when both are high.
  - SYNC: wait for vs_edge, then go to CAPTURE with counters cleared.
  - CAPTURE: on vs_edge, go to HANDOFF.
  - HANDOFF (one cycle):
    - If line_cnt >= GRID_H*STEP_Y and the frame is complete, then:
      - if tx_busy==0: tx_start=1, tx_bank=cap_bank, cap_bank toggles;
      - else: drop_cnt increments, saturating at 255, and the bank is kept.
    - If the frame is incomplete: frame_err=1, the bank is kept, and no tx_start.
    - Always return to CAPTURE; the vs_edge that caused HANDOFF starts the new frame (counters already cleared).
- Boundary conditions:
  - enable or pll_lock low in any state: go to IDLE the next cycle and suppress wr_en. No tx_start, frame_err or drop. cap_bank and drop_cnt are preserved.
  - tx_busy is sampled only in the HANDOFF cycle. tx_start is never asserted while tx_busy=1.
  - The first frame after SYNC is always captured in the current cap_bank.
  - vs_edge while de=1 (malformed timing): treated as a normal frame boundary.
  - Reset mid-frame: all state clears within one cycle; no pulses are emitted.

Decomposition:
- Package dvi_matrix_pkg holds:
  - typedef enum logic [1:0] {IDLE,SYNC,CAPTURE,HANDOFF} cap_state_t
  - typedef struct packed {logic [7:0] r,g,b;} rgb_t
  - grid default localparams
- One sub-module, dvi_cell_counter: per-axis counter parameterised by STEP and CELLS. It is instantiated twice, for x on de and y on de_fall. Outputs are sub, idx and valid.

Test Plan (parameters H_ACTIVE=32, V_ACTIVE=16, GRID_W=4, GRID_H=2, so STEP_X=8, STEP_Y=8):
1. Two full frames, tx_busy=0, pixel value = {y,x}:
   - 8 writes per frame at x in {4,12,20,28} and y in {4,12}.
   - Frame 1: wr_addr 0..7 in bank 0, data {4,4},{4,12},...
   - tx_start with tx_bank=0 at the second vs_edge+1.
   - The next frame writes addr 8..15 (bank 1).
2. tx_busy=1 at the frame boundary:
   - No tx_start; drop_cnt 0→1; the next frame rewrites bank 0.
3. Short frame (vs after 10 lines):
   - frame_err pulses once, no tx_start, bank unchanged.
4. pll_lock drops mid-line:
   - wr_en stays 0 from the next cycle.
   - After relock, nothing is written until a vs_edge.
   - cap_bank and drop_cnt unchanged.
5. 300 consecutive busy frame boundaries:
   - drop_cnt saturates at 255.
6. rst asserted mid-frame:
   - All outputs 0 the next cycle; capture resumes only after a vs_edge.

Source files
------------

// File: rtl/dvi_matrix_pkg.sv
// Shared types and defaults for the DVI-to-LED-matrix sampling path.
package dvi_matrix_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2,
    HANDOFF = 2'd3
  } cap_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Default geometry: 720p input onto a 4x4 arrangement of 16x8 panels.
  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_GRID_W   = 64;
  localparam int DEF_GRID_H   = 32;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dvi_cell_counter.sv
// One axis of the sample grid: position within a cell (sub) and cell index
// (idx). The index stops at CELLS, so anything past the last cell reads as
// invalid until the next clear.
module dvi_cell_counter
  import dvi_matrix_pkg::*;
#(
  parameter int STEP  = 8,
  parameter int CELLS = 4,
  parameter int SW    = cw(STEP),
  parameter int IW    = cw(CELLS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [SW-1:0] sub_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [SW-1:0] sub_q, sub_d;
  logic [IW-1:0] idx_q, idx_d;

  assign sub_o   = sub_q;
  assign idx_o   = idx_q;
  assign valid_o = (idx_q < IW'(CELLS));

  // Next position: clear wins, otherwise step through the cell and roll
  // into the next one; frozen once past the last cell.
  always_comb begin
    sub_d = sub_q;
    idx_d = idx_q;
    if (clr_i) begin
      sub_d = '0;
      idx_d = '0;
    end else if (adv_i && valid_o) begin
      if (sub_q == SW'(STEP - 1)) begin
        sub_d = '0;
        idx_d = idx_q + 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= '0;
      idx_q <= '0;
    end else begin
      sub_q <= sub_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/dvi_frame_sample_ctrl.sv
// Decimates each active DVI frame onto a GRID_W x GRID_H grid, writes the
// samples into one bank of a double-banked frame buffer and hands finished
// banks to the SPI transmitter.
//
// Transmitter handshake: tx_busy is looked at only in the single HANDOFF
// cycle. tx_start is a one-cycle pulse issued only if tx_busy was low in that
// cycle; tx_bank names the handed bank and holds until the next tx_start. If
// tx_busy was high the frame is dropped, counted, and its bank is reused.
module dvi_frame_sample_ctrl
  import dvi_matrix_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   GRID_W   = DEF_GRID_W,
  parameter int   GRID_H   = DEF_GRID_H,
  parameter logic VS_POL   = 1'b1,
  localparam int  AW       = $clog2(GRID_W * GRID_H) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          pll_lock,
  input  logic          vs,
  input  logic          de,
  input  logic [23:0]   rgb,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [23:0]   wr_data,
  output logic          tx_start,
  output logic          tx_bank,
  input  logic          tx_busy,
  output logic          frame_err,
  output logic [7:0]    drop_cnt,
  output cap_state_t    dbg_state
);

  localparam int STEP_X       = H_ACTIVE / GRID_W;
  localparam int STEP_Y       = V_ACTIVE / GRID_H;
  localparam int CELLS        = GRID_W * GRID_H;
  localparam int GXW          = cw(GRID_W);
  localparam int GYW          = cw(GRID_H);
  localparam int XSW          = cw(STEP_X);
  localparam int YSW          = cw(STEP_Y);
  localparam int XIW          = cw(GRID_W + 1);
  localparam int YIW          = cw(GRID_H + 1);
  localparam int CW           = cw(CELLS + 1);
  localparam int LW           = 16;
  localparam int LINES_NEEDED = GRID_H * STEP_Y;

  cap_state_t    state_q;
  logic          vs_q, de_q;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic          frame_ok_q;
  logic          cap_bank_q;
  logic          wr_en_q, tx_start_q, tx_bank_q, frame_err_q;
  logic [AW-1:0] wr_addr_q;
  rgb_t          wr_data_q;
  logic [7:0]    drop_cnt_q;

  logic           vs_edge, de_fall, run, sample, frame_ok;
  logic [XSW-1:0] x_sub;
  logic [XIW-1:0] x_idx;
  logic           x_valid;
  logic [YSW-1:0] y_sub;
  logic [YIW-1:0] y_idx;
  logic           y_valid;

  assign vs_edge = (vs == VS_POL) && (vs_q != VS_POL);
  assign de_fall = de_q && !de;
  assign run     = enable && pll_lock;

  // Horizontal position is held at zero through blanking so the first active
  // pixel of every line is column 0.
  dvi_cell_counter #(
    .STEP (STEP_X),
    .CELLS(GRID_W),
    .SW   (XSW),
    .IW   (XIW)
  ) u_x_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!de || vs_edge),
    .adv_i  (de),
    .sub_o  (x_sub),
    .idx_o  (x_idx),
    .valid_o(x_valid)
  );

  // Vertical position steps once per completed line.
  dvi_cell_counter #(
    .STEP (STEP_Y),
    .CELLS(GRID_H),
    .SW   (YSW),
    .IW   (YIW)
  ) u_y_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (vs_edge),
    .adv_i  (de_fall),
    .sub_o  (y_sub),
    .idx_o  (y_idx),
    .valid_o(y_valid)
  );

  // Centre pixel of each in-grid cell, only while actively capturing. The
  // vs_edge cycle itself belongs to no frame and is never sampled.
  assign sample = run && (state_q == CAPTURE) && !vs_edge && de &&
                  (x_sub == XSW'(STEP_X / 2)) && (y_sub == YSW'(STEP_Y / 2)) &&
                  x_valid && y_valid;

  // A frame is good when every line of the grid was seen and every cell got
  // exactly one sample.
  assign frame_ok = (line_cnt_q >= LW'(LINES_NEEDED)) && (wr_cnt_q == CW'(CELLS));

  // Per-frame line and write counters, restarted at every frame boundary.
  always_comb begin
    line_cnt_d = line_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    if (vs_edge) begin
      line_cnt_d = '0;
      wr_cnt_d   = '0;
    end else begin
      if (de_fall && (line_cnt_q != '1)) line_cnt_d = line_cnt_q + 1'b1;
      if (sample && (wr_cnt_q != CW'(CELLS))) wr_cnt_d = wr_cnt_q + 1'b1;
    end
  end

  // Capture FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vs_q        <= VS_POL;
      de_q        <= 1'b0;
      line_cnt_q  <= '0;
      wr_cnt_q    <= '0;
      frame_ok_q  <= 1'b0;
      cap_bank_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      tx_start_q  <= 1'b0;
      tx_bank_q   <= 1'b0;
      frame_err_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      vs_q        <= vs;
      de_q        <= de;
      line_cnt_q  <= line_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_en_q     <= sample;
      tx_start_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (sample) begin
        wr_addr_q <= {cap_bank_q, GYW'(y_idx), GXW'(x_idx)};
        wr_data_q <= rgb;
      end
      if (!run) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE:    state_q <= SYNC;
          SYNC:    if (vs_edge) state_q <= CAPTURE;
          CAPTURE: begin
            if (vs_edge) begin
              frame_ok_q <= frame_ok;
              state_q    <= HANDOFF;
            end
          end
          HANDOFF: begin
            state_q <= CAPTURE;
            if (frame_ok_q) begin
              if (!tx_busy) begin
                tx_start_q <= 1'b1;
                tx_bank_q  <= cap_bank_q;
                cap_bank_q <= ~cap_bank_q;
              end else begin
                drop_cnt_q <= sat_inc8(drop_cnt_q);
              end
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign tx_start  = tx_start_q;
  assign tx_bank   = tx_bank_q;
  assign frame_err = frame_err_q;
  assign drop_cnt  = drop_cnt_q;
  assign dbg_state = state_q;

endmodule
